// File: rtl/seq_det_pkg.sv
// Shared types and constants for the serial bit-pattern detector.
// Reset configuration detects "101" without overlap.
package seq_det_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    localparam logic [3:0] DEF_PAT  = 4'b0101;
    localparam logic [2:0] DEF_LEN  = 3'd3;
    localparam logic       DEF_OVL  = 1'b0;

    localparam logic [2:0] LEN_MIN  = 3'd2;
    localparam logic [2:0] LEN_MAX  = 3'd4;

    function automatic logic [2:0] clamp_len(input logic [2:0] len);
        if (len < LEN_MIN) return LEN_MIN;
        if (len > LEN_MAX) return LEN_MAX;
        return len;
    endfunction

endpackage

// File: rtl/seq_det_ctrl_if.sv
// Byte-in / result-out handshake bundle of the pattern detector.
interface seq_det_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [CNT_W-1:0]  out_cnt;
    logic              out_hit;
    logic              out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_cnt, out_hit
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_cnt, out_hit
    );
endinterface

// File: rtl/seq_match_core.sv
// Bit history, fill tracking and pattern compare for one serialised byte.
// match is combinational on the bit presented this cycle.
module seq_match_core
    import seq_det_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       bit_vld,
    input  logic       bit_in,
    input  logic [3:0] pat,
    input  logic [2:0] len,
    input  logic       ovl,
    output logic       match
);

    logic [3:0] r_hist;
    logic [2:0] r_fill;

    logic [3:0] w_hist_next;
    logic [2:0] w_fill_inc;
    logic [4:0] w_mask_wide;
    logic [3:0] w_mask;

    assign w_hist_next = {r_hist[2:0], bit_in};
    assign w_fill_inc  = (r_fill >= LEN_MAX) ? LEN_MAX : r_fill + 3'd1;
    // len is already clamped to 2..4, so the mask never needs more than 4 bits
    assign w_mask_wide = (5'd1 << len) - 5'd1;
    assign w_mask      = w_mask_wide[3:0];

    assign match = bit_vld && (w_fill_inc >= len)
                   && (((w_hist_next ^ pat) & w_mask) == 4'd0);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_hist <= 4'd0;
            r_fill <= 3'd0;
        end else if (bit_vld) begin
            r_hist <= w_hist_next;
            r_fill <= (match && !ovl) ? 3'd0 : w_fill_inc;
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Accepts a byte, serialises it MSB first into the match core and reports
// the number of pattern matches found within that byte.
//
// state     | meaning
// ST_IDLE   | ready for a byte, config writes accepted
// ST_SHIFT  | feeding DATA_W bits into the match core
// ST_REPORT | result held until out_ready
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_we,
    input  logic [3:0] cfg_pat,
    input  logic [2:0] cfg_len,
    input  logic       cfg_ovl,
    seq_det_ctrl_if.slave bus,
    output logic       busy
);

    localparam int               IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t            r_state;
    logic [DATA_W-1:0] r_byte;
    logic [IDX_W-1:0]  r_idx;
    logic [CNT_W-1:0]  r_cnt;
    logic [3:0]        r_pat;
    logic [2:0]        r_len;
    logic              r_ovl;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [CNT_W-1:0]  r_out_cnt;
    logic              r_out_hit;
    logic              r_busy;

    logic              w_accept;
    logic              w_bit_vld;
    logic              w_bit;
    logic              w_match;
    logic [CNT_W-1:0]  w_cnt_next;

    assign w_accept   = (r_state == ST_IDLE) && bus.in_valid;
    assign w_bit_vld  = (r_state == ST_SHIFT);
    assign w_bit      = r_byte[r_idx];
    assign w_cnt_next = (w_match && (r_cnt != CNT_MAX)) ? r_cnt + CNT_W'(1) : r_cnt;

    seq_match_core u_core (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_accept),
        .bit_vld (w_bit_vld),
        .bit_in  (w_bit),
        .pat     (r_pat),
        .len     (r_len),
        .ovl     (r_ovl),
        .match   (w_match)
    );

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_cnt   = r_out_cnt;
    assign bus.out_hit   = r_out_hit;
    assign busy          = r_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_byte      <= '0;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_pat       <= DEF_PAT;
            r_len       <= DEF_LEN;
            r_ovl       <= DEF_OVL;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_cnt   <= '0;
            r_out_hit   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // config latched here is already in force for a byte accepted this cycle
                    if (cfg_we) begin
                        r_pat <= cfg_pat;
                        r_len <= clamp_len(cfg_len);
                        r_ovl <= cfg_ovl;
                    end
                    if (bus.in_valid) begin
                        r_byte     <= bus.in_data;
                        r_cnt      <= '0;
                        r_idx      <= IDX_LAST;
                        r_state    <= ST_SHIFT;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    r_cnt <= w_cnt_next;
                    if (r_idx == '0) begin
                        r_state     <= ST_REPORT;
                        r_out_valid <= 1'b1;
                        r_out_cnt   <= w_cnt_next;
                        r_out_hit   <= (w_cnt_next != '0);
                    end else begin
                        r_idx <= r_idx - IDX_W'(1);
                    end
                end
                ST_REPORT: begin
                    if (bus.out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed vector bench for seq_det_ctrl: table of bytes/configs plus
// hand-written stall, config-during-shift and mid-shift reset sequences.
module tb_seq_det_ctrl;

    logic       clk;
    logic       rst;
    logic       cfg_we;
    logic [3:0] cfg_pat;
    logic [2:0] cfg_len;
    logic       cfg_ovl;
    logic       busy;

    int n_chk  = 0;
    int n_pass = 0;

    seq_det_ctrl_if #(.DATA_W(8), .CNT_W(4)) bus ();

    seq_det_ctrl #(.DATA_W(8), .CNT_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .cfg_we  (cfg_we),
        .cfg_pat (cfg_pat),
        .cfg_len (cfg_len),
        .cfg_ovl (cfg_ovl),
        .bus     (bus.slave),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       do_cfg;
        logic [3:0] pat;
        logic [2:0] len;
        logic       ovl;
        logic [7:0] data;
        int         exp_cnt;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    // called #1 after a posedge while the DUT is idle; returns #1 after the accept edge
    task automatic send(input logic [7:0] d, input logic cfg, input logic [3:0] p,
                        input logic [2:0] l, input logic o);
        chk("in_ready_idle", {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        cfg_we       = cfg;
        cfg_pat      = p;
        cfg_len      = l;
        cfg_ovl      = o;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        cfg_we       = 1'b0;
    endtask

    // waits for out_valid, checking it lands 8 edges after the accept edge
    task automatic wait_result(input string nm, input int exp, input int edges_done);
        int n;
        n = edges_done;
        while (!bus.out_valid && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({nm, "_valid"},   {31'd0, bus.out_valid}, 32'd1);
        chk({nm, "_latency"}, n, 32'd8);
        chk({nm, "_cnt"},     {28'd0, bus.out_cnt}, exp);
        chk({nm, "_hit"},     {31'd0, bus.out_hit}, (exp != 0) ? 32'd1 : 32'd0);
        if (bus.out_ready) begin
            @(posedge clk);
            #1;
            chk({nm, "_done"}, {31'd0, bus.out_valid}, 32'd0);
        end
    endtask

    initial begin
        vecs[0] = '{1'b0, 4'b0000, 3'd0, 1'b0, 8'b1010_1010, 2};
        vecs[1] = '{1'b1, 4'b0101, 3'd3, 1'b1, 8'b1010_1010, 3};
        vecs[2] = '{1'b1, 4'b1111, 3'd4, 1'b0, 8'hFF,        2};
        vecs[3] = '{1'b1, 4'b1111, 3'd4, 1'b1, 8'hFF,        5};
        vecs[4] = '{1'b1, 4'b1111, 3'd4, 1'b1, 8'h00,        0};
        vecs[5] = '{1'b1, 4'b1101, 3'd0, 1'b0, 8'b0101_0101, 4};
        vecs[6] = '{1'b1, 4'b1111, 3'd7, 1'b0, 8'hFF,        2};
        vecs[7] = '{1'b1, 4'b0110, 3'd3, 1'b1, 8'b1101_1011, 2};
        vecs[8] = '{1'b1, 4'b0011, 3'd2, 1'b1, 8'hFF,        7};

        rst          = 1'b1;
        cfg_we       = 1'b0;
        cfg_pat      = 4'd0;
        cfg_len      = 3'd0;
        cfg_ovl      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_busy",      {31'd0, busy},          32'd0);
        chk("rst_out_cnt",   {28'd0, bus.out_cnt},   32'd0);
        chk("rst_out_hit",   {31'd0, bus.out_hit},   32'd0);

        for (int i = 0; i < 9; i++) begin
            send(vecs[i].data, vecs[i].do_cfg, vecs[i].pat, vecs[i].len, vecs[i].ovl);
            chk($sformatf("vec%0d_busy", i), {31'd0, busy}, 32'd1);
            wait_result($sformatf("vec%0d", i), vecs[i].exp_cnt, 0);
        end

        // result held while the consumer stalls
        bus.out_ready = 1'b0;
        send(8'b1010_1010, 1'b1, 4'b0101, 3'd3, 1'b0);
        wait_result("stall", 2, 0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("stall_valid",    {31'd0, bus.out_valid}, 32'd1);
            chk("stall_cnt",      {28'd0, bus.out_cnt},   32'd2);
            chk("stall_hit",      {31'd0, bus.out_hit},   32'd1);
            chk("stall_in_ready", {31'd0, bus.in_ready},  32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_release_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("stall_release_ready", {31'd0, bus.in_ready},  32'd1);

        // config write during SHIFT must be dropped
        send(8'b1010_1010, 1'b1, 4'b0101, 3'd3, 1'b0);
        @(posedge clk);
        #1;
        cfg_we  = 1'b1;
        cfg_pat = 4'b0011;
        cfg_len = 3'd2;
        cfg_ovl = 1'b1;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        wait_result("shift_cfg", 2, 2);
        send(8'b1010_1010, 1'b0, 4'b0000, 3'd0, 1'b0);
        wait_result("after_shift_cfg", 2, 0);

        // reset in the 4th SHIFT cycle, with other inputs active during reset
        send(8'b1010_1010, 1'b1, 4'b0101, 3'd3, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst          = 1'b1;
        cfg_we       = 1'b1;
        cfg_pat      = 4'b1111;
        cfg_len      = 3'd4;
        cfg_ovl      = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        @(posedge clk);
        #1;
        chk("midrst_busy",      {31'd0, busy},          32'd0);
        chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midrst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        rst          = 1'b0;
        cfg_we       = 1'b0;
        bus.in_valid = 1'b0;
        send(8'b1010_1010, 1'b0, 4'b0000, 3'd0, 1'b0);
        wait_result("after_midrst", 2, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/seq_det_ctrl.md
SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, is the byte width serialised per transaction.
REQ-002 Parameter CNT_W, default 4, is the match-counter width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 cfg_we  input  1  configuration write strobe.
REQ-006 cfg_pat  input  4  pattern bits; cfg_pat[len-1] is the oldest bit, cfg_pat[0] the newest.
REQ-007 cfg_len  input  3  pattern length in bits.
REQ-008 cfg_ovl  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-009 in_valid  input  1  input byte valid.
REQ-010 in_data  input  DATA_W  byte to scan.
REQ-011 in_ready  output  1  controller can accept a byte.
REQ-012 out_valid  output  1  result valid.
REQ-013 out_cnt  output  CNT_W  number of matches in the byte.
REQ-014 out_hit  output  1  out_cnt != 0.
REQ-015 out_ready  input  1  result consumer ready.
REQ-016 busy  output  1  state != IDLE.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, SHIFT and REPORT.
REQ-018 In IDLE, in_ready SHALL be 1; in all other states it SHALL be 0.
REQ-019 In IDLE, in_valid=1 SHALL capture in_data and clear the counter, history, fill and bit index, then go to SHIFT.
REQ-020 In IDLE, cfg_we=1 SHALL latch cfg_pat, cfg_len and cfg_ovl; cfg_we in SHIFT or REPORT SHALL be ignored.
REQ-021 When cfg_we and in_valid coincide in IDLE, the new config SHALL apply to the byte accepted in that cycle.
REQ-022 Latched cfg_len SHALL be clamped: values below 2 use 2, values above 4 use 4.
REQ-023 SHIFT SHALL last exactly DATA_W cycles and feed one bit per cycle, MSB first, into the history shift register.
REQ-024 A bit SHALL count as a match when fill >= len and the last len history bits equal cfg_pat[len-1:0].
REQ-025 Fill SHALL count valid history bits and saturate at 4.
REQ-026 On a match with cfg_ovl=0, fill SHALL be cleared to 0, so the next match needs len fresh bits.
REQ-027 On a match with cfg_ovl=1, fill SHALL be unchanged.
REQ-028 On each match the counter SHALL increment, saturating at 2^CNT_W-1.
REQ-029 Matches SHALL NOT span bytes, because history and fill are cleared on each accept.
REQ-030 After the last SHIFT bit the FSM SHALL enter REPORT with out_valid=1 and out_cnt/out_hit driven.
REQ-031 Latency: accept at cycle T SHALL give out_valid at T+DATA_W+1.
REQ-032 out_valid, out_cnt and out_hit SHALL stay stable while out_ready=0.
REQ-033 out_valid & out_ready SHALL return the FSM to IDLE on the next cycle.
REQ-034 Throughput: at most one byte per DATA_W+2 cycles.

Reset
REQ-035 While rst=1, all inputs SHALL be ignored.
REQ-036 Reset SHALL force state IDLE, counter 0, fill 0, out_valid 0, out_cnt 0, out_hit 0, busy 0.
REQ-037 Reset SHALL set config to pat=4'b0101, len=3, ovl=0, which detects 101 non-overlapping.
REQ-038 Reset mid-SHIFT or mid-REPORT SHALL abort and discard the transaction.
REQ-039 in_ready SHALL be 1 from the first cycle after rst deasserts.

Structure
REQ-040 Package seq_det_pkg SHALL hold the state enum, the default pattern/length/overlap constants and the length clamp limits 2 and 4.
REQ-041 Sub-module seq_match_core SHALL hold the history, fill, compare and overlap logic, with ports clk, rst, clr, bit_vld, bit_in, pat, len, ovl and match.
REQ-042 seq_det_ctrl SHALL contain only the FSM, byte register, bit index, counter and handshakes.

Verification
REQ-043 After reset (default config), byte 8'b1010_1010 -> out_cnt=2, out_hit=1, out_valid at T+9.
REQ-044 Config pat=0101, len=3, ovl=1, then byte 8'b1010_1010 -> out_cnt=3.
REQ-045 pat=1111, len=4: byte 8'hFF with ovl=0 -> 2; with ovl=1 -> 5; byte 8'h00 -> out_cnt=0, out_hit=0.
REQ-046 out_ready held 0 for 5 cycles in REPORT -> outputs stable and in_ready=0; cfg_we pulsed during SHIFT -> next byte uses the old config.
REQ-047 rst asserted in the 4th SHIFT cycle -> next cycle IDLE, out_valid=0, config back to defaults; a following 8'b1010_1010 -> out_cnt=2.
REQ-048 cfg_len=0 or 7 -> behaves as 2 or 4 respectively; e.g. pat=xx01, len=0, byte 8'b0101_0101 -> out_cnt=4 (ovl=0).
